// File: rtl/fifo_share_pkg.sv
// fifo_share_pkg: shared types, default widths and helpers for the
// fifo_share_sched block and its round-robin arbiter.
//   op_t    - the one operation chosen per cycle (idle, push or pop)
//   DEF_*   - default parameter values for the scheduler
//   clog2   - ceiling log2, never returning less than 1 bit
package fifo_share_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP
  } op_t;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_MSBD       = 3;
  localparam int unsigned DEF_MSBA       = 3;
  localparam int unsigned DEF_STARVE_MAX = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_share_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req [NREQ-1:0] - request vector, bit i = requester i
//   ptr [PW-1:0]   - highest-priority index; search runs upward and wraps
//   gnt [NREQ-1:0] - one-hot grant (all zero when nothing requests)
//   win [PW-1:0]   - index of the granted requester
//   any            - at least one request is present
module rr_arbiter
  import fifo_share_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned PW   = clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        win      = PW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_share_sched.sv
// fifo_share_sched: shares one ring-buffer FIFO between NREQ producers and
// a single consumer. At most one FIFO operation per cycle: a round-robin
// granted push, or a pop. A starvation counter forces a pop slot after
// STARVE_MAX consecutive push-won cycles with a serviceable pop pending.
// Decisions are combinational (zero latency); the FIFO updates on the
// same clock edge.
//   clock, rst      - rising-edge clock, synchronous active-high reset
//   req, req_data   - producer push requests and packed data slices
//   gnt             - one-hot push grant
//   pop_req         - consumer pop request
//   pop_ack, pop_data - pop performed this cycle, head element
//   fifo_push, fifo_pop, fifo_data_in - drive the FIFO
//   fifo_data_out, fifo_full, fifo_empty - from the FIFO
// Optional: define FIFO_SHARE_SCHED_OCC_EN to add output occ, a shadow
// occupancy count checked against the FIFO flags in simulation.
module fifo_share_sched
  import fifo_share_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned MSBD       = DEF_MSBD,
  parameter int unsigned MSBA       = DEF_MSBA,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(MSBD+1)-1:0]   req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       pop_req,
  output logic                       pop_ack,
  output logic [MSBD:0]              pop_data,
  output logic                       fifo_push,
  output logic                       fifo_pop,
  output logic [MSBD:0]              fifo_data_in,
  input  logic [MSBD:0]              fifo_data_out,
  input  logic                       fifo_full,
  input  logic                       fifo_empty
`ifdef FIFO_SHARE_SCHED_OCC_EN
  ,
  output logic [MSBA+1:0]            occ
`endif
);

  localparam int unsigned PW = clog2(NREQ);
  localparam int unsigned SW = clog2(STARVE_MAX + 1);

  logic [PW-1:0]   rr_ptr;
  logic [SW-1:0]   starve_cnt;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_win;
  logic            arb_any;
  logic            push_cand;
  logic            pop_cand;
  logic            force_pop;
  op_t             op;

  rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .win(arb_win),
    .any(arb_any)
  );

  assign push_cand = arb_any & ~fifo_full;
  assign pop_cand  = pop_req & ~fifo_empty;
  assign force_pop = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    op = OP_IDLE;
    if (rst)                        op = OP_IDLE;
    else if (force_pop && pop_cand) op = OP_POP;
    else if (push_cand)             op = OP_PUSH;
    else if (pop_cand)              op = OP_POP;
  end

  always_comb begin
    gnt          = '0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    pop_ack      = 1'b0;
    fifo_data_in = '0;
    pop_data     = rst ? '0 : fifo_data_out;
    case (op)
      OP_PUSH: begin
        gnt          = arb_gnt;
        fifo_push    = 1'b1;
        fifo_data_in = req_data[32'(arb_win)*(MSBD+1) +: (MSBD+1)];
      end
      OP_POP: begin
        fifo_pop = 1'b1;
        pop_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (op == OP_PUSH)
        rr_ptr <= (arb_win == PW'(NREQ - 1)) ? '0 : arb_win + 1'b1;
      // Counter only advances while a serviceable pop is being passed over.
      if (op == OP_POP || !pop_cand)
        starve_cnt <= '0;
      else if (op == OP_PUSH && !force_pop)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef FIFO_SHARE_SCHED_OCC_EN
  localparam int unsigned DEPTH = 1 << (MSBA + 1);

  always_ff @(posedge clock) begin
    if (rst)                occ <= '0;
    else if (op == OP_PUSH) occ <= occ + 1'b1;
    else if (op == OP_POP)  occ <= occ - 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!rst) begin
      assert ((occ == '0) == fifo_empty)
        else $error("occ=%0d disagrees with fifo_empty=%0b", occ, fifo_empty);
      assert ((occ == (MSBA+2)'(DEPTH)) == fifo_full)
        else $error("occ=%0d disagrees with fifo_full=%0b", occ, fifo_full);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_fifo_share_sched.sv
module tb_fifo_share_sched;

  logic        clock;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        pop_req;
  logic        pop_ack;
  logic [3:0]  pop_data;
  logic        fifo_push;
  logic        fifo_pop;
  logic [3:0]  fifo_data_in;
  logic [3:0]  fifo_data_out;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef FIFO_SHARE_SCHED_OCC_EN
  logic [4:0]  occ;
`endif

  fifo_share_sched #(
    .NREQ      (4),
    .MSBD      (3),
    .MSBA      (3),
    .STARVE_MAX(3)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .pop_req      (pop_req),
    .pop_ack      (pop_ack),
    .pop_data     (pop_data),
    .fifo_push    (fifo_push),
    .fifo_pop     (fifo_pop),
    .fifo_data_in (fifo_data_in),
    .fifo_data_out(fifo_data_out),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
`ifdef FIFO_SHARE_SCHED_OCC_EN
    ,
    .occ          (occ)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ring-buffer FIFO 16x4, push has priority over pop.
  logic [3:0] f_mem [16];
  logic [3:0] f_wr, f_rd;
  logic [4:0] f_cnt;
  assign fifo_full     = (f_cnt == 5'd16);
  assign fifo_empty    = (f_cnt == 5'd0);
  assign fifo_data_out = f_mem[f_rd];

  always_ff @(posedge clock) begin
    if (rst) begin
      f_wr  <= '0;
      f_rd  <= '0;
      f_cnt <= '0;
    end else if (fifo_push) begin
      if (!fifo_full) begin
        f_mem[f_wr] <= fifo_data_in;
        f_wr        <= f_wr + 1'b1;
        f_cnt       <= f_cnt + 1'b1;
      end
    end else if (fifo_pop && !fifo_empty) begin
      f_rd  <= f_rd + 1'b1;
      f_cnt <= f_cnt - 1'b1;
    end
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state and scoreboard of expected FIFO contents.
  int unsigned m_rr = 0;
  int unsigned m_starve = 0;
  logic [3:0]  m_q[$];
  logic [3:0]  last_gnt;
  logic        last_push, last_pop, last_ack;
  logic [3:0]  last_pop_data;

  // Check one cycle at the falling edge, advance the model, step past the
  // rising edge. Inputs must already be set by the caller.
  task automatic cycle();
    logic [3:0] eg, ed;
    logic       pc, oc, fp;
    int         win, op;
    @(negedge clock);
    last_gnt      = gnt;
    last_push     = fifo_push;
    last_pop      = fifo_pop;
    last_ack      = pop_ack;
    last_pop_data = pop_data;
    if (rst) begin
      check("rst_ctl", {gnt, fifo_push, fifo_pop, pop_ack, fifo_data_in, pop_data}, '0);
      m_rr = 0;
      m_starve = 0;
      m_q.delete();
    end else begin
      check("flags", {fifo_full, fifo_empty}, {m_q.size() == 16, m_q.size() == 0});
`ifdef FIFO_SHARE_SCHED_OCC_EN
      check("occ", occ, m_q.size());
`endif
      pc  = (req != 0) && (m_q.size() < 16);
      oc  = pop_req && (m_q.size() > 0);
      fp  = (m_starve == 3);
      win = -1;
      for (int off = 0; off < 4; off++)
        if (win < 0 && req[(int'(m_rr) + off) % 4]) win = (int'(m_rr) + off) % 4;
      if (fp && oc)  op = 2;
      else if (pc)   op = 1;
      else if (oc)   op = 2;
      else           op = 0;
      eg = (op == 1) ? 4'(1 << win) : 4'd0;
      ed = (op == 1) ? req_data[win*4 +: 4] : 4'd0;
      check("ctl", {gnt, fifo_push, fifo_pop, pop_ack, fifo_data_in},
            {eg, op == 1, op == 2, op == 2, ed});
      if (op == 2) check("pop_data", pop_data, m_q.pop_front());
      if (op == 1) begin
        m_q.push_back(ed);
        m_rr = (win + 1) % 4;
      end
      if (op == 2 || !oc) m_starve = 0;
      else if (op == 1 && m_starve < 3) m_starve++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    pop_req = 1'b0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    check("empty_after_rst", fifo_empty, 1);

    // Round-robin sequence across all four producers.
    req = 4'hF;
    req_data = 16'h4321;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_seq", last_gnt, 32'(1 << i));
    end
    for (int i = 0; i < 4; i++) check("fifo_order", f_mem[i], i + 1);

    // Fill to full, then a held request must wait for a pop.
    for (int i = 0; i < 12; i++) cycle();
    check("full", fifo_full, 1);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("full_nogrant", {last_gnt, last_push}, 0);
    end
    pop_req = 1'b1;
    cycle();
    check("full_pop", {last_pop, last_ack}, 2'b11);
    pop_req = 1'b0;
    cycle();
    check("after_pop_gnt", last_gnt, 4'b0001);

    // Starvation: 5 entries, push traffic and pop request both sustained.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = 4'b0001;
    req_data = 16'h0005;
    for (int i = 0; i < 5; i++) cycle();
    req = 4'b0011;
    req_data = 16'h0076;
    pop_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("starve_pat", {last_push, last_pop}, (i % 4 == 3) ? 2'b01 : 2'b10);
    end

    // Empty FIFO: pop request ignored; single push then pop returns it.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = '0;
    pop_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("empty_pop", last_ack, 0);
    end
    pop_req = 1'b0;
    req = 4'b0001;
    req_data = 16'h000A;
    cycle();
    req = '0;
    pop_req = 1'b1;
    cycle();
    check("pop_a", {last_ack, last_pop_data}, {1'b1, 4'hA});
    pop_req = 1'b0;
    check("empty_again", fifo_empty, 1);

    // Reset in the middle of a burst.
    req = 4'hF;
    req_data = 16'h9876;
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b1;
    cycle();
    check("rst_mid", {last_gnt, last_push, last_pop, last_ack}, 0);
    rst = 1'b0;
    check("rst_empty", fifo_empty, 1);
    cycle();
    check("rst_rr", last_gnt, 4'b0001);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      req      = 4'($urandom_range(0, 15));
      req_data = 16'($urandom);
      pop_req  = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
